// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the sequential ALU (seq_alu).
//   alu_op_e    : 2-bit operation code (ADD, SUB, MUL_LO, MUL_HI)
//   alu_state_e : control FSM states (IDLE, MUL, DONE)
//   sat_max/min : signed saturation limits for a given width (returned
//                 zero-extended to 64 bits; callers cast to their width)
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ADD    = 2'd0,
    SUB    = 2'd1,
    MUL_LO = 2'd2,
    MUL_HI = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Largest signed value of the given width: 0111...1
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Smallest signed value of the given width: 1000...0
  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if
// Handshake bundle between the control unit and seq_alu.
//   request : in_valid, in_ready, op, a, b
//   response: out_valid, out_ready, result, overflow
// Modports: master = control unit side, slave = ALU side.
// ---------------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  alu_pkg::alu_op_e     op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 overflow;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, overflow
  );

endinterface

// File: rtl/shift_add_mul.sv
// ---------------------------------------------------------------------------
// shift_add_mul
// Iterative unsigned WIDTH x WIDTH multiplier, one shift-add step per cycle.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   load            : start a new multiply with mcand/mplier
//   mcand, mplier   : unsigned operands (WIDTH)
//   busy            : high while iterations remain after the current cycle
//   product         : unsigned 2*WIDTH product, complete once busy has
//                     dropped and the final step has been taken
// ---------------------------------------------------------------------------
module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      count_reg;
  logic               run_reg;
  logic [WIDTH-1:0]   mcand_reg;
  // Upper half accumulates partial sums; lower half starts as the
  // multiplier and is shifted out LSB first as the product shifts in.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH:0]     partial;

  assign partial = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      run_reg   <= 1'b0;
      mcand_reg <= '0;
      acc_reg   <= '0;
    end else if (load) begin
      count_reg <= CW'(WIDTH - 1);
      run_reg   <= 1'b1;
      mcand_reg <= mcand;
      acc_reg   <= {{WIDTH{1'b0}}, mplier};
    end else if (run_reg) begin
      acc_reg <= {partial, acc_reg[WIDTH-1:1]};
      if (count_reg == '0) begin
        run_reg <= 1'b0;
      end else begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Drops in the cycle the last step is taken, so the caller can leave its
  // wait state on the same edge that completes the product.
  assign busy    = run_reg && (count_reg != '0);
  assign product = acc_reg;

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Handshaked signed ALU: ADD, SUB (1 cycle) and MUL_LO/MUL_HI (WIDTH cycles,
// iterative), with signed overflow flag and optional saturation.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : seq_alu_if slave (in_valid/in_ready/op/a/b request side,
//                out_valid/out_ready/result/overflow response side)
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(sat_min(WIDTH));

  alu_state_e         state_reg, state_next;
  alu_op_e            op_reg;
  logic               sign_reg;
  logic [WIDTH-1:0]   sum_result_reg;
  logic               sum_overflow_reg;

  logic               accept;
  logic               is_mul_op;
  logic               mul_load;
  logic               mul_busy;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] signed_product;
  logic               mul_lo_ovf;
  logic [WIDTH:0]     a_ext, b_ext, sum_ext;
  logic               sum_ovf;
  logic [WIDTH-1:0]   sum_final;

  assign accept    = bus.in_valid && (state_reg == IDLE);
  assign is_mul_op = (bus.op == MUL_LO) || (bus.op == MUL_HI);
  assign mul_load  = accept && is_mul_op;

  // Magnitudes fit in WIDTH unsigned bits, including |min| = 2^(WIDTH-1).
  assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .mcand   (a_mag),
    .mplier  (b_mag),
    .busy    (mul_busy),
    .product (mul_product)
  );

  // Add/sub at WIDTH+1 bits; overflow when the two top bits disagree.
  assign a_ext     = {bus.a[WIDTH-1], bus.a};
  assign b_ext     = {bus.b[WIDTH-1], bus.b};
  assign sum_ext   = (bus.op == SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
  assign sum_ovf   = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
  assign sum_final = (SATURATE && sum_ovf) ? (sum_ext[WIDTH] ? MIN_VAL : MAX_VAL)
                                           : sum_ext[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg           <= ADD;
      sign_reg         <= 1'b0;
      sum_result_reg   <= '0;
      sum_overflow_reg <= 1'b0;
    end else if (accept) begin
      op_reg   <= bus.op;
      sign_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      if (!is_mul_op) begin
        sum_result_reg   <= sum_final;
        sum_overflow_reg <= sum_ovf;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.in_valid) state_next = is_mul_op ? MUL : DONE;
      MUL:  if (!mul_busy)    state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Product magnitude is stable once the multiplier stops, so the signed
  // product and its selection are derived from registers only.
  assign signed_product = sign_reg ? -mul_product : mul_product;
  // MUL_LO fits only if the top WIDTH+1 bits are a pure sign extension.
  assign mul_lo_ovf = !((&signed_product[2*WIDTH-1:WIDTH-1]) ||
                        (~|signed_product[2*WIDTH-1:WIDTH-1]));

  always_comb begin
    bus.result   = sum_result_reg;
    bus.overflow = sum_overflow_reg;
    case (op_reg)
      MUL_HI: begin
        bus.result   = signed_product[2*WIDTH-1:WIDTH];
        bus.overflow = 1'b0;
      end
      MUL_LO: begin
        bus.overflow = mul_lo_ovf;
        bus.result   = (SATURATE && mul_lo_ovf)
                     ? (signed_product[2*WIDTH-1] ? MIN_VAL : MAX_VAL)
                     : signed_product[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu at WIDTH=8. Two instances (SATURATE=0 and
// SATURATE=1) receive identical stimulus so each vector checks both modes.
// ---------------------------------------------------------------------------
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct {
    alu_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res0;
    logic       ovf0;
    logic [7:0] res1;
    logic       ovf1;
  } vec_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs[16];

  seq_alu_if #(.WIDTH(8)) bus0 ();
  seq_alu_if #(.WIDTH(8)) bus1 ();

  seq_alu #(.WIDTH(8), .SATURATE(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0)
  );

  seq_alu #(.WIDTH(8), .SATURATE(1'b1)) u_dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input alu_op_e op, input logic [7:0] a,
                       input logic [7:0] b, input logic ordy);
    bus0.in_valid = v;  bus1.in_valid = v;
    bus0.op = op;       bus1.op = op;
    bus0.a = a;         bus1.a = a;
    bus0.b = b;         bus1.b = b;
    bus0.out_ready = ordy; bus1.out_ready = ordy;
  endtask

  function automatic logic [8:0] ref_model(input alu_op_e op, input logic [7:0] a,
                                           input logic [7:0] b, input bit sat);
    int v;
    logic [31:0] p;
    logic [7:0] r;
    logic o;
    case (op)
      ADD:     v = int'($signed(a)) + int'($signed(b));
      SUB:     v = int'($signed(a)) - int'($signed(b));
      default: v = int'($signed(a)) * int'($signed(b));
    endcase
    p = v;
    if (op == MUL_HI) begin
      r = p[15:8];
      o = 1'b0;
    end else begin
      o = (v > 127) || (v < -128);
      r = p[7:0];
      if (sat && o) r = (v > 0) ? 8'h7F : 8'h80;
    end
    return {r, o};
  endfunction

  // Presents one op for one cycle, then waits (bounded) for out_valid.
  // Returns cycles from accept edge to first out_valid sample.
  task automatic do_op(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                       input logic ordy, output int lat);
    drive(1'b1, op, a, b, ordy);
    @(posedge clk); #1;
    drive(1'b0, ADD, ~a, ~b, ordy);   // scrambled inputs must be ignored
    lat = 1;
    while (!bus0.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int exp_lat;
    exp_lat = (v.op == MUL_LO || v.op == MUL_HI) ? 9 : 1;
    check({tag, "_in_ready_pre"}, {31'd0, bus0.in_ready}, 32'd1);
    do_op(v.op, v.a, v.b, 1'b1, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_res0"}, {24'd0, bus0.result}, {24'd0, v.res0});
    check({tag, "_ovf0"}, {31'd0, bus0.overflow}, {31'd0, v.ovf0});
    check({tag, "_res1"}, {24'd0, bus1.result}, {24'd0, v.res1});
    check({tag, "_ovf1"}, {31'd0, bus1.overflow}, {31'd0, v.ovf1});
    @(posedge clk); #1;
    check({tag, "_in_ready_post"}, {30'd0, bus0.in_ready, bus1.in_ready}, 32'd3);
  endtask

  initial begin
    int lat;
    int seen;
    int w;
    alu_op_e op;
    logic [7:0] ra, rb;
    logic [8:0] e0, e1;

    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0]  = '{ADD,    8'h64, 8'h32, 8'h96, 1'b1, 8'h7F, 1'b1};
    vecs[1]  = '{SUB,    8'h80, 8'h01, 8'h7F, 1'b1, 8'h80, 1'b1};
    vecs[2]  = '{MUL_LO, 8'h03, 8'hFB, 8'hF1, 1'b0, 8'hF1, 1'b0};
    vecs[3]  = '{MUL_HI, 8'h03, 8'hFB, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[4]  = '{MUL_HI, 8'h80, 8'h80, 8'h40, 1'b0, 8'h40, 1'b0};
    vecs[5]  = '{MUL_LO, 8'h80, 8'h80, 8'h00, 1'b1, 8'h7F, 1'b1};
    vecs[6]  = '{ADD,    8'h07, 8'h09, 8'h10, 1'b0, 8'h10, 1'b0};
    vecs[7]  = '{MUL_LO, 8'h0C, 8'h0B, 8'h84, 1'b1, 8'h7F, 1'b1};
    vecs[8]  = '{SUB,    8'h05, 8'h0A, 8'hFB, 1'b0, 8'hFB, 1'b0};
    vecs[9]  = '{ADD,    8'h9C, 8'hCE, 8'h6A, 1'b1, 8'h80, 1'b1};
    vecs[10] = '{MUL_LO, 8'h00, 8'hFB, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{MUL_HI, 8'h00, 8'hFB, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{MUL_LO, 8'hFF, 8'hFF, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[13] = '{MUL_HI, 8'h7F, 8'h7F, 8'h3F, 1'b0, 8'h3F, 1'b0};
    vecs[14] = '{MUL_LO, 8'h80, 8'h01, 8'h80, 1'b0, 8'h80, 1'b0};
    vecs[15] = '{ADD,    8'h7F, 8'h80, 8'hFF, 1'b0, 8'hFF, 1'b0};

    // Reset state
    rst = 1'b1;
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b1);
    #12;
    check("rst_in_ready",  {30'd0, bus0.in_ready, bus1.in_ready}, 32'd3);
    check("rst_out_valid", {30'd0, bus0.out_valid, bus1.out_valid}, 32'd0);
    check("rst_result",    {16'd0, bus0.result, bus1.result}, 32'd0);
    check("rst_overflow",  {30'd0, bus0.overflow, bus1.overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      $display("vec %0d: op=%0d a=%02h b=%02h -> res0=%02h res1=%02h",
               i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res0, vecs[i].res1);
    end

    // Backpressure: ADD 7+9, out_ready low for 5 cycles, in_valid kept high
    drive(1'b1, ADD, 8'h07, 8'h09, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, SUB, 8'($urandom), 8'($urandom), 1'b0);
      check($sformatf("bp%0d_out_valid", i), {31'd0, bus0.out_valid}, 32'd1);
      check($sformatf("bp%0d_in_ready", i),  {30'd0, bus0.in_ready, bus1.in_ready}, 32'd0);
      check($sformatf("bp%0d_result", i),    {16'd0, bus0.result, bus1.result}, 32'h1010);
      @(posedge clk); #1;
    end
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b1);
    check("bp_result_release", {24'd0, bus0.result}, 32'h10);
    @(posedge clk); #1;
    check("bp_in_ready_after", {30'd0, bus0.in_ready, bus0.out_valid}, 32'd2);
    $display("backpressure: ADD 7+9 held for 5 cycles");

    // Reset mid-multiply
    drive(1'b1, MUL_LO, 8'h0C, 8'h0B, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  {30'd0, bus0.in_ready, bus1.in_ready}, 32'd3);
    check("midrst_out_valid", {30'd0, bus0.out_valid, bus1.out_valid}, 32'd0);
    check("midrst_result",    {16'd0, bus0.result, bus1.result}, 32'd0);
    #2;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus0.out_valid || bus1.out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    run_vec(vecs[7], "midrst_redo");
    $display("reset mid-multiply: redo MUL_LO 12x11 -> %02h", bus0.result);

    // Random back-to-back ops with random out_ready
    for (int n = 0; n < 1000; n++) begin
      op = alu_op_e'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      e0 = ref_model(op, ra, rb, 1'b0);
      e1 = ref_model(op, ra, rb, 1'b1);
      do_op(op, ra, rb, 1'b0, lat);
      check($sformatf("rnd%0d", n),
            {6'd0, bus0.result, bus0.overflow, bus1.result, bus1.overflow, 8'(lat)},
            {6'd0, e0, e1, ((op == MUL_LO || op == MUL_HI) ? 8'd9 : 8'd1)});
      $display("rnd %0d: op=%0d a=%02h b=%02h res0=%02h res1=%02h lat=%0d",
               n, op, ra, rb, bus0.result, bus1.result, lat);
      w = 0;
      while (bus0.out_valid && w < 40) begin
        drive(1'b0, ADD, 8'h00, 8'h00, (w >= 30) ? 1'b1 : 1'($urandom));
        @(posedge clk); #1;
        w++;
      end
      if (bus0.out_valid) check($sformatf("rnd%0d_drain", n), 32'd1, 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
